// File: rtl/matmul_pkg.sv
// matmul_pkg: shared types and helpers for the matrix-multiply engine.
//   state_t       FSM state encoding (IDLE / MAC / WRITE / DONE)
//   DEF_*         default element and bus widths
//   row_shift()   brings element `col` of a packed row down to bit 0
//   add_overflow() signed two-operand add overflow from the three sign bits
package matmul_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_BUS_WIDTH  = 32;

  // Upper bound on BUS_WIDTH supported by row_shift().
  localparam int MAX_BUS = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Caller truncates the result to its element width.
  function automatic logic [MAX_BUS-1:0] row_shift(input logic [MAX_BUS-1:0] row,
                                                   input int col,
                                                   input int data_w);
    return row >> (col * data_w);
  endfunction

  function automatic logic add_overflow(input logic a_sign,
                                        input logic b_sign,
                                        input logic sum_sign);
    return (a_sign == b_sign) && (sum_sign != a_sign);
  endfunction

endpackage

// File: rtl/matmul_mac_unit.sv
// matmul_mac_unit: combinational signed multiply-accumulate step.
//   a, b  signed DATA_WIDTH operands
//   acc   current BUS_WIDTH accumulator
//   sum   acc + sext(a*b), wrapping modulo 2^BUS_WIDTH
//   ovf   signed overflow of that addition
module matmul_mac_unit
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BUS_WIDTH  = DEF_BUS_WIDTH
) (
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  input  logic        [BUS_WIDTH-1:0]  acc,
  output logic        [BUS_WIDTH-1:0]  sum,
  output logic                         ovf
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic        [BUS_WIDTH-1:0]    prod_ext;

  assign prod     = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);
  assign prod_ext = BUS_WIDTH'(prod);
  assign sum      = acc + prod_ext;
  assign ovf      = add_overflow(acc[BUS_WIDTH-1], prod_ext[BUS_WIDTH-1], sum[BUS_WIDTH-1]);

endmodule

// File: rtl/matmul_mac_engine.sv
// matmul_mac_engine: sequential signed C = A*B (+ bias) engine, one MAC per cycle,
// results streamed out over a valid/ready write-back port.
//   clk_i, rst_i                 clock, synchronous active-high reset
//   start_i, mode_i              job start (IDLE only), accumulate-onto-bias mode
//   n_dim_i, k_dim_i, m_dim_i    dimensions minus one
//   mat_a_i, mat_b_i, bias_i     packed operands, latched at start
//   c_ready_i / c_valid_o        write-back handshake; c_addr_o = n*MAX_DIM+m, c_data_o
//   flags_o                      sticky per-element overflow flags
//   busy_o, done_o               activity level, one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for start_i
// MAC   | one multiply-accumulate per cycle over k
// WRITE | presenting acc for element (n,m) until c_ready_i
// DONE  | one-cycle done pulse
module matmul_mac_engine
  import matmul_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int BUS_WIDTH  = DEF_BUS_WIDTH,
  localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
  localparam int DW         = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1,
  localparam int AW         = (MAX_DIM > 1) ? $clog2(MAX_DIM * MAX_DIM) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 start_i,
  input  logic                                 mode_i,
  input  logic [DW-1:0]                        n_dim_i,
  input  logic [DW-1:0]                        k_dim_i,
  input  logic [DW-1:0]                        m_dim_i,
  input  logic [MAX_DIM*BUS_WIDTH-1:0]         mat_a_i,
  input  logic [MAX_DIM*BUS_WIDTH-1:0]         mat_b_i,
  input  logic [MAX_DIM*MAX_DIM*BUS_WIDTH-1:0] bias_i,
  input  logic                                 c_ready_i,
  output logic                                 c_valid_o,
  output logic [AW-1:0]                        c_addr_o,
  output logic [BUS_WIDTH-1:0]                 c_data_o,
  output logic [MAX_DIM*MAX_DIM-1:0]           flags_o,
  output logic                                 busy_o,
  output logic                                 done_o
);

  state_t state_q, state_d;

  logic                                       mode_q;
  logic [DW-1:0]                              n_dim_q, k_dim_q, m_dim_q;
  logic [DW-1:0]                              n_q, k_q, m_q;
  logic [BUS_WIDTH-1:0]                       acc_q;
  logic [MAX_DIM-1:0][BUS_WIDTH-1:0]          a_q, b_q;
  logic [MAX_DIM*MAX_DIM-1:0][BUS_WIDTH-1:0]  bias_q;
  logic [MAX_DIM*MAX_DIM-1:0]                 flags_q;

  logic signed [DATA_WIDTH-1:0] elem_a, elem_b;
  logic [BUS_WIDTH-1:0]         mac_sum;
  logic                         mac_ovf;
  logic [AW-1:0]                cur_addr, next_addr;
  logic [DW-1:0]                next_n, next_m;
  logic                         last_k, last_elem;

  assign elem_a = DATA_WIDTH'(row_shift(MAX_BUS'(a_q[n_q]), int'(k_q), DATA_WIDTH));
  assign elem_b = DATA_WIDTH'(row_shift(MAX_BUS'(b_q[k_q]), int'(m_q), DATA_WIDTH));

  matmul_mac_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUS_WIDTH  (BUS_WIDTH)
  ) u_mac (
    .a   (elem_a),
    .b   (elem_b),
    .acc (acc_q),
    .sum (mac_sum),
    .ovf (mac_ovf)
  );

  assign last_k    = (k_q == k_dim_q);
  assign last_elem = (n_q == n_dim_q) && (m_q == m_dim_q);
  assign next_m    = (m_q == m_dim_q) ? '0 : m_q + DW'(1);
  assign next_n    = (m_q == m_dim_q) ? n_q + DW'(1) : n_q;
  assign cur_addr  = AW'(n_q) * AW'(MAX_DIM) + AW'(m_q);
  assign next_addr = AW'(next_n) * AW'(MAX_DIM) + AW'(next_m);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_MAC;
      ST_MAC:   if (last_k) state_d = ST_WRITE;
      ST_WRITE: if (c_ready_i) state_d = last_elem ? ST_DONE : ST_MAC;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Address/data are forced to zero outside WRITE so the port is quiet when idle.
  always_comb begin
    c_valid_o = (state_q == ST_WRITE);
    c_addr_o  = c_valid_o ? cur_addr : '0;
    c_data_o  = c_valid_o ? acc_q : '0;
    busy_o    = (state_q != ST_IDLE);
    done_o    = (state_q == ST_DONE);
  end

  assign flags_o = flags_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q  <= 1'b0;
      n_dim_q <= '0;
      k_dim_q <= '0;
      m_dim_q <= '0;
      n_q     <= '0;
      k_q     <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      bias_q  <= '0;
      flags_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            mode_q  <= mode_i;
            n_dim_q <= n_dim_i;
            k_dim_q <= k_dim_i;
            m_dim_q <= m_dim_i;
            a_q     <= mat_a_i;
            b_q     <= mat_b_i;
            bias_q  <= bias_i;
            n_q     <= '0;
            k_q     <= '0;
            m_q     <= '0;
            flags_q <= '0;
            acc_q   <= mode_i ? bias_i[BUS_WIDTH-1:0] : '0;
          end
        end
        ST_MAC: begin
          acc_q <= mac_sum;
          if (mac_ovf) flags_q[cur_addr] <= 1'b1;
          if (!last_k) k_q <= k_q + DW'(1);
        end
        ST_WRITE: begin
          if (c_ready_i && !last_elem) begin
            n_q   <= next_n;
            m_q   <= next_m;
            k_q   <= '0;
            acc_q <= mode_q ? bias_q[next_addr] : '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_mac_engine.sv
module tb_matmul_mac_engine;

  localparam int DATA_WIDTH = 8;
  localparam int BUS_WIDTH  = 32;
  localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH;
  localparam int DW         = $clog2(MAX_DIM);
  localparam int AW         = $clog2(MAX_DIM * MAX_DIM);
  localparam int NE         = MAX_DIM * MAX_DIM;
  localparam longint LIM    = 64'sd2147483648;

  logic                       clk_i = 1'b0;
  logic                       rst_i, start_i, mode_i, c_ready_i;
  logic [DW-1:0]              n_dim_i, k_dim_i, m_dim_i;
  logic [MAX_DIM*BUS_WIDTH-1:0] mat_a_i, mat_b_i;
  logic [NE*BUS_WIDTH-1:0]    bias_i;
  logic                       c_valid_o, busy_o, done_o;
  logic [AW-1:0]              c_addr_o;
  logic [BUS_WIDTH-1:0]       c_data_o;
  logic [NE-1:0]              flags_o;

  matmul_mac_engine #(.DATA_WIDTH(DATA_WIDTH), .BUS_WIDTH(BUS_WIDTH)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .mode_i    (mode_i),
    .n_dim_i   (n_dim_i),
    .k_dim_i   (k_dim_i),
    .m_dim_i   (m_dim_i),
    .mat_a_i   (mat_a_i),
    .mat_b_i   (mat_b_i),
    .bias_i    (bias_i),
    .c_ready_i (c_ready_i),
    .c_valid_o (c_valid_o),
    .c_addr_o  (c_addr_o),
    .c_data_o  (c_data_o),
    .flags_o   (flags_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  always #5 clk_i = ~clk_i;

  int a_m[MAX_DIM][MAX_DIM];
  int b_m[MAX_DIM][MAX_DIM];
  int bias_m[NE];
  int exp_c[NE];
  logic [NE-1:0] exp_flags;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
  endtask

  function automatic int rb();
    logic [7:0] r = 8'($urandom);
    return int'($signed(r));
  endfunction

  // Mathematical reference: exact integer sums, wrapped to 32 bits after each
  // step; overflow is any exact partial sum leaving the signed 32-bit range.
  function automatic void model(bit mode, int nn, int kk, int mm);
    longint acc, ex;
    bit     fl;
    exp_flags = '0;
    for (int i = 0; i < NE; i++) exp_c[i] = 0;
    for (int n = 0; n < nn; n++)
      for (int m = 0; m < mm; m++) begin
        acc = mode ? longint'(bias_m[n*MAX_DIM+m]) : 0;
        fl  = 0;
        for (int k = 0; k < kk; k++) begin
          ex = acc + longint'(a_m[n][k]) * longint'(b_m[k][m]);
          if (ex >= LIM || ex < -LIM) fl = 1;
          acc = longint'(int'(ex));
        end
        exp_c[n*MAX_DIM+m]     = int'(acc);
        exp_flags[n*MAX_DIM+m] = fl;
      end
  endfunction

  task automatic fill_random();
    for (int r = 0; r < MAX_DIM; r++)
      for (int c = 0; c < MAX_DIM; c++) begin
        a_m[r][c] = rb();
        b_m[r][c] = rb();
      end
    for (int i = 0; i < NE; i++) bias_m[i] = int'($urandom);
  endtask

  task automatic pack();
    for (int r = 0; r < MAX_DIM; r++)
      for (int c = 0; c < MAX_DIM; c++) begin
        mat_a_i[r*BUS_WIDTH + c*DATA_WIDTH +: DATA_WIDTH] = a_m[r][c][7:0];
        mat_b_i[r*BUS_WIDTH + c*DATA_WIDTH +: DATA_WIDTH] = b_m[r][c][7:0];
      end
    for (int i = 0; i < NE; i++) bias_i[i*BUS_WIDTH +: BUS_WIDTH] = bias_m[i];
  endtask

  task automatic scramble();
    for (int w = 0; w < MAX_DIM; w++) begin
      mat_a_i[w*BUS_WIDTH +: BUS_WIDTH] = $urandom;
      mat_b_i[w*BUS_WIDTH +: BUS_WIDTH] = $urandom;
    end
    for (int i = 0; i < NE; i++) bias_i[i*BUS_WIDTH +: BUS_WIDTH] = $urandom;
    n_dim_i = DW'($urandom);
    k_dim_i = DW'($urandom);
    m_dim_i = DW'($urandom);
    mode_i  = ~mode_i;
  endtask

  task automatic run_job(input string name, input bit mode, input int nn, input int kk,
                         input int mm, input int stall, input bit poke, input int rst_at);
    int t, wi, busy_cnt, done_cnt, first_valid, stall_left, seen, en, em;
    logic [AW-1:0]  hold_addr;
    logic [31:0]    hold_data;
    bit held, aborted;
    model(mode, nn, kk, mm);
    pack();
    mode_i  = mode;
    n_dim_i = DW'(nn - 1);
    k_dim_i = DW'(kk - 1);
    m_dim_i = DW'(mm - 1);
    c_ready_i = 1'b1;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    chk({name, ":busy_rise"}, 32'(busy_o), 1);
    t = 0; wi = 0; busy_cnt = 0; done_cnt = 0; first_valid = -1;
    stall_left = stall; held = 0; aborted = 0;
    while (t < 1000) begin
      if (!busy_o) break;
      busy_cnt++;
      if (done_o) begin
        done_cnt++;
        chk({name, ":done_at"}, t, nn*mm*(kk+1) + stall);
      end
      if (poke && t == 1) begin
        scramble();
        start_i = 1'b1;
      end else begin
        start_i = 1'b0;
      end
      if (c_valid_o) begin
        if (first_valid < 0) begin
          first_valid = t;
          chk({name, ":first_valid"}, t, kk);
        end
        if (rst_at == wi) begin
          rst_i = 1'b1;
          @(posedge clk_i); #1;
          rst_i = 1'b0;
          chk({name, ":rst_valid"}, 32'(c_valid_o), 0);
          chk({name, ":rst_addr"},  32'(c_addr_o), 0);
          chk({name, ":rst_data"},  c_data_o, 0);
          chk({name, ":rst_flags"}, 32'(flags_o), 0);
          chk({name, ":rst_busy"},  32'(busy_o), 0);
          chk({name, ":rst_done"},  32'(done_o), 0);
          seen = 0;
          repeat (8) begin
            @(posedge clk_i); #1;
            if (c_valid_o || busy_o) seen++;
          end
          chk({name, ":rst_quiet"}, seen, 0);
          aborted = 1;
          break;
        end
        if (wi == 0 && stall_left > 0) begin
          if (!held) begin
            hold_addr = c_addr_o;
            hold_data = c_data_o;
            held = 1;
          end else begin
            chk({name, ":stall_addr"}, 32'(c_addr_o), 32'(hold_addr));
            chk({name, ":stall_data"}, c_data_o, hold_data);
          end
          c_ready_i = 1'b0;
          stall_left--;
        end else begin
          c_ready_i = 1'b1;
          en = wi / mm;
          em = wi % mm;
          chk({name, ":addr"}, 32'(c_addr_o), en*MAX_DIM + em);
          chk({name, ":data"}, c_data_o, exp_c[en*MAX_DIM + em]);
          wi++;
        end
      end else begin
        c_ready_i = 1'b1;
      end
      @(posedge clk_i); #1;
      t++;
    end
    start_i   = 1'b0;
    c_ready_i = 1'b1;
    if (!aborted) begin
      if (t >= 1000) chk({name, ":timeout"}, 0, 1);
      chk({name, ":writes"},   wi, nn*mm);
      chk({name, ":busy_len"}, busy_cnt, nn*mm*(kk+1) + 1 + stall);
      chk({name, ":done_cnt"}, done_cnt, 1);
      chk({name, ":flags"},    32'(flags_o), 32'(exp_flags));
    end
  endtask

  initial begin
    int nn, kk, mm;
    rst_i = 1'b1; start_i = 1'b1; mode_i = 1'b0; c_ready_i = 1'b1;
    n_dim_i = '0; k_dim_i = '0; m_dim_i = '0;
    mat_a_i = '0; mat_b_i = '0; bias_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset:valid", 32'(c_valid_o), 0);
    chk("reset:addr",  32'(c_addr_o), 0);
    chk("reset:data",  c_data_o, 0);
    chk("reset:flags", 32'(flags_o), 0);
    chk("reset:busy",  32'(busy_o), 0);
    chk("reset:done",  32'(done_o), 0);
    rst_i = 1'b0; start_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;

    fill_random();
    a_m[0][0] = 1; a_m[0][1] = 2; a_m[1][0] = 3; a_m[1][1] = 4;
    b_m[0][0] = 5; b_m[0][1] = 6; b_m[1][0] = 7; b_m[1][1] = 8;
    run_job("t2x2", 0, 2, 2, 2, 0, 0, -1);

    fill_random();
    for (int r = 0; r < MAX_DIM; r++)
      for (int c = 0; c < MAX_DIM; c++) a_m[r][c] = (r == c) ? 1 : 0;
    for (int i = 0; i < NE; i++) bias_m[i] = 10;
    run_job("ident", 1, MAX_DIM, MAX_DIM, MAX_DIM, 0, 0, -1);

    for (int r = 0; r < MAX_DIM; r++)
      for (int c = 0; c < MAX_DIM; c++) begin
        a_m[r][c] = -128;
        b_m[r][c] = -128;
      end
    for (int i = 0; i < NE; i++) bias_m[i] = 32'h7FFF_FFFF;
    run_job("ovf", 1, MAX_DIM, MAX_DIM, MAX_DIM, 0, 0, -1);

    fill_random();
    run_job("bp", 1, 3, 2, 4, 3, 0, -1);

    fill_random();
    run_job("poke", 1, 4, 3, 4, 0, 1, -1);

    fill_random();
    run_job("rstw", 0, 2, 3, 2, 0, 0, 1);

    fill_random();
    run_job("fresh", 1, 3, 3, 3, 0, 0, -1);

    fill_random();
    run_job("min", 0, 1, 1, 1, 0, 0, -1);

    fill_random();
    run_job("k1", 1, 4, 1, 4, 1, 0, -1);

    for (int j = 0; j < 8; j++) begin
      fill_random();
      nn = $urandom_range(1, MAX_DIM);
      kk = $urandom_range(1, MAX_DIM);
      mm = $urandom_range(1, MAX_DIM);
      run_job($sformatf("rnd%0d", j), 1'($urandom), nn, kk, mm,
              $urandom_range(0, 2), 0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
